// File: rtl/vend_sequencer.sv
// vend_sequencer -- central controller for the vending datapath.
//
// Detects rising edges on the debounced coin/button levels, keeps a binary
// credit register and sequences IDLE -> CREDIT -> READY -> VEND -> CHANGE,
// returning change one nickel at a time with a fixed gap between pulses.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   dime         debounced dime level
//   nickel       debounced nickel level
//   dispense_btn debounced dispense request level
//   cancel_btn   debounced cancel/refund request level
//   credit_bcd   {4'h0, 4'h0, tens, ones} of the current credit
//   locked_led   high while READY
//   dispense_led high while VEND
//   change       one-cycle pulse, each returns 5 cents
//   coin_reject  one-cycle pulse when a coin edge is refused
//   busy         high in VEND or CHANGE
//
// Optional feature: define VEND_REFUND_TIMEOUT_EN to auto-refund the credit
// after TIMEOUT_CYCLES of inactivity in CREDIT or READY.
module vend_sequencer #(
  parameter int unsigned PRICE           = 25,
  parameter int unsigned CREDIT_MAX      = 95,
  parameter int unsigned DISPENSE_CYCLES = 100000000,
  parameter int unsigned CHANGE_GAP      = 25000000,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dime,
  input  logic        nickel,
  input  logic        dispense_btn,
  input  logic        cancel_btn,
  output logic [15:0] credit_bcd,
  output logic        locked_led,
  output logic        dispense_led,
  output logic        change,
  output logic        coin_reject,
  output logic        busy
);

  if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > CREDIT_MAX ||
      (CREDIT_MAX % 5) != 0 || CREDIT_MAX > 95 ||
      DISPENSE_CYCLES < 1 || CHANGE_GAP < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("vend_sequencer: illegal parameter combination");
  end

  localparam logic [6:0]  PRICE7    = 7'(PRICE);
  localparam logic [7:0]  PRICE8    = 8'(PRICE);
  localparam logic [7:0]  MAX8      = 8'(CREDIT_MAX);
  localparam logic [31:0] DISP_LAST = 32'(DISPENSE_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD  = 32'(CHANGE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    READY  = 3'd2,
    VEND   = 3'd3,
    CHANGE = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [6:0]  credit, credit_next;
  logic [31:0] vend_cnt, vend_cnt_next;
  logic [31:0] gap_cnt, gap_cnt_next;
  logic        coin_reject_next;

  // Bit order {dime, nickel, dispense_btn, cancel_btn}. The input is first
  // registered into samp, and the edge is taken between samp and prev, so an
  // event sampled at one edge is acted on at the following edge.
  logic [3:0] samp, prev, ev;
  logic       dime_ev, nickel_ev, dispense_ev, cancel_ev, coin_ev;

  logic [6:0] coin_val;
  logic [7:0] coin_sum;

`ifdef VEND_REFUND_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] inact_cnt, inact_cnt_next;
`endif

  assign ev          = samp & ~prev;
  assign dime_ev     = ev[3];
  assign nickel_ev   = ev[2];
  assign dispense_ev = ev[1];
  assign cancel_ev   = ev[0];
  assign coin_ev     = dime_ev | nickel_ev;

  assign credit_bcd   = {8'h00, 4'(credit / 7'd10), 4'(credit % 7'd10)};
  assign locked_led   = (state == READY);
  assign dispense_led = (state == VEND);
  assign busy         = (state == VEND) || (state == CHANGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      vend_cnt    <= '0;
      gap_cnt     <= '0;
      coin_reject <= 1'b0;
      samp        <= '1;
      prev        <= '1;
`ifdef VEND_REFUND_TIMEOUT_EN
      inact_cnt   <= '0;
`endif
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      vend_cnt    <= vend_cnt_next;
      gap_cnt     <= gap_cnt_next;
      coin_reject <= coin_reject_next;
      samp        <= {dime, nickel, dispense_btn, cancel_btn};
      prev        <= samp;
`ifdef VEND_REFUND_TIMEOUT_EN
      inact_cnt   <= inact_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next       = state;
    credit_next      = credit;
    vend_cnt_next    = '0;
    gap_cnt_next     = '0;
    coin_reject_next = 1'b0;
    change           = 1'b0;
    coin_val         = dime_ev ? 7'd10 : 7'd5;
    coin_sum         = {1'b0, credit} + {1'b0, coin_val};
`ifdef VEND_REFUND_TIMEOUT_EN
    inact_cnt_next   = '0;
`endif

    case (state)
      IDLE, CREDIT: begin
        // Simultaneous coins: the dime is considered, the nickel is dropped.
        if (dime_ev && nickel_ev) coin_reject_next = 1'b1;
        if (coin_ev) begin
          if (coin_sum > MAX8) begin
            coin_reject_next = 1'b1;
          end else begin
            credit_next = coin_sum[6:0];
            state_next  = (coin_sum >= PRICE8) ? READY : CREDIT;
          end
        end
        // Cancel refunds everything held, including a coin landing this cycle.
        if (state == CREDIT && cancel_ev) state_next = CHANGE;
      end

      READY: begin
        if (coin_ev) coin_reject_next = 1'b1;
        if (dispense_ev) begin
          credit_next = credit - PRICE7;
          state_next  = VEND;
        end else if (cancel_ev) begin
          state_next = CHANGE;
        end
      end

      VEND: begin
        if (coin_ev) coin_reject_next = 1'b1;
        if (vend_cnt == DISP_LAST) state_next = CHANGE;
        else                       vend_cnt_next = vend_cnt + 32'd1;
      end

      CHANGE: begin
        if (coin_ev) coin_reject_next = 1'b1;
        if (credit == '0) begin
          state_next = IDLE;
        end else if (gap_cnt == '0) begin
          change       = 1'b1;
          credit_next  = credit - 7'd5;
          gap_cnt_next = GAP_LOAD;
        end else begin
          gap_cnt_next = gap_cnt - 32'd1;
        end
      end

      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase

`ifdef VEND_REFUND_TIMEOUT_EN
    // Only overrides state_next when no event occurred, so it never races
    // the normal coin/button handling above.
    if (state == CREDIT || state == READY) begin
      if (coin_ev || dispense_ev || cancel_ev) inact_cnt_next = '0;
      else if (inact_cnt == TO_LAST)          state_next = CHANGE;
      else                                    inact_cnt_next = inact_cnt + 32'd1;
    end
`endif
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios followed by
// randomized coin/button transactions, checked against a transaction-level
// credit model (running sum, refund = credit/5 nickels at fixed spacing).
module tb_vend_sequencer;

  localparam int PRICE = 25;
  localparam int MAXC  = 95;
  localparam int DC    = 4;
  localparam int GAP   = 3;
  localparam int TO    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dime = 1'b0, nickel = 1'b0, dispense_btn = 1'b0, cancel_btn = 1'b0;
  logic [15:0] credit_bcd;
  logic        locked_led, dispense_led, change, coin_reject, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_credit = 0;

  vend_sequencer #(
    .PRICE(PRICE),
    .CREDIT_MAX(MAXC),
    .DISPENSE_CYCLES(DC),
    .CHANGE_GAP(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dime(dime),
    .nickel(nickel),
    .dispense_btn(dispense_btn),
    .cancel_btn(cancel_btn),
    .credit_bcd(credit_bcd),
    .locked_led(locked_led),
    .dispense_led(dispense_led),
    .change(change),
    .coin_reject(coin_reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd(input int c);
    return (c / 10) * 16 + (c % 10);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input bit d, input bit n);
    int val;
    bit accept, rej;
    dime = d;
    nickel = n;
    tick;
    check("coin_latency", 32'(credit_bcd), bcd(m_credit));
    tick;
    val    = d ? 10 : 5;
    accept = (m_credit < PRICE) && (m_credit + val <= MAXC);
    rej    = !accept || (d && n);
    if (accept) m_credit += val;
    check("coin_credit", 32'(credit_bcd), bcd(m_credit));
    check("coin_reject", 32'(coin_reject), 32'(rej));
    check("coin_locked", 32'(locked_led), 32'(m_credit >= PRICE));
    dime = 1'b0;
    nickel = 1'b0;
    tick;
    check("coin_reject_1cyc", 32'(coin_reject), 0);
    tick;
  endtask

  // Starts on the first CHANGE cycle; expects n_exp nickels, the first one
  // immediately, then every GAP cycles, then one extra cycle before IDLE.
  task automatic observe_change(input int n_exp);
    int cyc = 0, npulse = 0, last = -1, first = -1;
    bit spacing_ok = 1'b1;
    while (busy && cyc < 1000) begin
      if (change) begin
        if (npulse == 0) first = cyc;
        else if (cyc - last != GAP) spacing_ok = 1'b0;
        last = cyc;
        npulse++;
      end
      tick;
      cyc++;
    end
    check("change_count", npulse, n_exp);
    if (n_exp > 0) check("change_first", first, 0);
    check("change_spacing", 32'(spacing_ok), 1);
    check("change_cycles", cyc, (n_exp == 0) ? 1 : (n_exp - 1) * GAP + 2);
    check("refund_credit", 32'(credit_bcd), 0);
    m_credit = 0;
  endtask

  task automatic press_dispense;
    int n;
    dispense_btn = 1'b1;
    tick;
    tick;
    dispense_btn = 1'b0;
    if (m_credit >= PRICE) begin
      m_credit -= PRICE;
      check("vend_led", 32'(dispense_led), 1);
      check("vend_busy", 32'(busy), 1);
      check("vend_credit", 32'(credit_bcd), bcd(m_credit));
      n = 1;
      while (n < 1000) begin
        tick;
        if (!dispense_led) break;
        n++;
      end
      check("vend_len", n, DC);
      observe_change(m_credit / 5);
    end else begin
      check("disp_ignored_led", 32'(dispense_led), 0);
      check("disp_ignored_credit", 32'(credit_bcd), bcd(m_credit));
    end
    tick;
  endtask

  task automatic press_cancel;
    cancel_btn = 1'b1;
    tick;
    tick;
    cancel_btn = 1'b0;
    if (m_credit > 0) begin
      check("cancel_busy", 32'(busy), 1);
      observe_change(m_credit / 5);
    end else begin
      check("cancel_ignored", 32'(busy), 0);
    end
    tick;
  endtask

  initial begin
    int c;
    bit saw_busy;

    // 1: reset with dime held high, no phantom edge afterwards
    rst = 1'b1;
    dime = 1'b1;
    tick; tick; tick;
    check("rst_bcd", 32'(credit_bcd), 0);
    check("rst_locked", 32'(locked_led), 0);
    check("rst_disp", 32'(dispense_led), 0);
    check("rst_change", 32'(change), 0);
    check("rst_reject", 32'(coin_reject), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick; tick; tick;
    check("held_dime_bcd", 32'(credit_bcd), 0);
    check("held_dime_reject", 32'(coin_reject), 0);
    dime = 1'b0;
    tick; tick;
    coin(1, 0);

    // 2: exact price, extra coin refused, vend with no change
    m_credit = 10;
    coin(1, 0);
    coin(0, 1);
    coin(0, 1);
    press_dispense;

    // 3: 30 cents, one nickel back
    coin(1, 0); coin(1, 0); coin(1, 0);
    press_dispense;

    // 4: 15 cents refunded by cancel
    coin(0, 1); coin(1, 0);
    press_cancel;

    // 5: simultaneous coins, then reset in the middle of VEND
    coin(1, 1);
    coin(1, 0); coin(0, 1);
    dispense_btn = 1'b1;
    tick; tick;
    dispense_btn = 1'b0;
    check("pre_rst_vend", 32'(dispense_led), 1);
    tick;
    rst = 1'b1;
    tick;
    check("midvend_rst_bcd", 32'(credit_bcd), 0);
    check("midvend_rst_disp", 32'(dispense_led), 0);
    check("midvend_rst_busy", 32'(busy), 0);
    check("midvend_rst_change", 32'(change), 0);
    check("midvend_rst_locked", 32'(locked_led), 0);
    rst = 1'b0;
    m_credit = 0;
    tick; tick;
    check("post_rst_change", 32'(change), 0);

    // 6: inactivity with 20 cents held
    coin(1, 0);
    dime = 1'b1;
    tick; tick;
    dime = 1'b0;
    m_credit = 20;
    check("hold20_credit", 32'(credit_bcd), bcd(20));
`ifdef VEND_REFUND_TIMEOUT_EN
    c = 0;
    while (!busy && c < 200) begin
      tick;
      c++;
    end
    check("timeout_cycles", c, TO);
    observe_change(4);
`else
    saw_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (busy) saw_busy = 1'b1;
    end
    check("hold_no_busy", 32'(saw_busy), 0);
    check("hold_credit", 32'(credit_bcd), bcd(20));
    press_cancel;
`endif

    // Randomized transactions against the credit model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: coin(1, 0);
        1: coin(0, 1);
        2: coin(1, 1);
        3: press_dispense;
        4: press_cancel;
        default: begin
          tick;
          check("idle_credit", 32'(credit_bcd), bcd(m_credit));
          check("idle_locked", 32'(locked_led), 32'(m_credit >= PRICE));
        end
      endcase
    end
    press_cancel;
    check("final_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
